// File: rtl/sc_pkg.sv
// Shared constants, state type and width helper for the stochastic-stream decoder.
package sc_pkg;

    localparam int unsigned N_DEFAULT = 8;
    localparam int unsigned POW2N     = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Result holds 0..2^N unipolar or -2^N..+2^N bipolar, hence N+2 bits.
    function automatic int unsigned res_width(input int unsigned n);
        return n + 2;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Window sample counter and ones accumulator; flags the final sample of a 2^N window.
module sc_ones_counter #(
    parameter int unsigned N = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [N:0] o_count_c,
    output logic       o_last_c
);

    localparam int unsigned CW       = N + 1;
    localparam logic [N:0]  LAST_IDX = CW'((2 ** N) - 1);

    logic [N:0] r_samp;
    logic [N:0] r_ones;

    // Count including the sample presented this cycle; equals the final count on the last sample.
    assign o_count_c = r_ones + CW'(i_bit);
    assign o_last_c  = i_en && (r_samp == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset || i_clear || o_last_c) begin
            r_samp <= '0;
            r_ones <= '0;
        end else if (i_en) begin
            r_samp <= r_samp + CW'(1);
            r_ones <= o_count_c;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^N-sample window and
// presents the (unipolar or bipolar) result on a ready/valid output.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned BIPOLAR    = 0,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         sc_bit,
    input  logic         sc_valid,
    input  logic         out_ready,
    output logic [N+1:0] out_value,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned   RW  = res_width(N);
    localparam logic [RW-1:0] POW = RW'(2 ** N);

    state_t          r_state;
    state_t          w_next;
    logic            w_clear;
    logic            w_en;
    logic            w_last;
    logic [N:0]      w_count;
    logic [RW-1:0]   w_uni;
    logic [RW-1:0]   w_result;
    logic [RW-1:0]   r_value;
    logic            r_valid;
    logic            r_overrun;

    sc_ones_counter #(
        .N (N)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_en      (w_en),
        .i_bit     (sc_bit),
        .o_count_c (w_count),
        .o_last_c  (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                if (w_last && (CONTINUOUS == 0)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Counters are held clear while idle so a window always starts from zero.
    always_comb begin
        w_clear = 1'b0;
        w_en    = 1'b0;
        busy    = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
            end
            COUNT: begin
                w_en = sc_valid;
                busy = 1'b1;
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    // Bipolar mapping 2*C - 2^N, wrapped into RW-bit two's complement.
    assign w_uni    = RW'(w_count);
    assign w_result = (BIPOLAR != 0) ? ((w_uni << 1) - POW) : w_uni;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_last) begin
            r_value <= w_result;
            r_valid <= 1'b1;
            if (r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_value = r_value;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: three configurations share one stimulus and are
// compared each cycle against a window-level reference model, plus directed windows.
module tb_sc_stream_decoder;
    import sc_pkg::*;

    localparam int unsigned N    = N_DEFAULT;
    localparam int unsigned W    = N + 2;
    localparam int          WIN  = int'(POW2N);
    localparam int          NDUT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sc_bit = 1'b0;
    logic sc_valid = 1'b0;
    logic out_ready = 1'b0;

    logic [W-1:0] d_value [NDUT];
    logic         d_valid [NDUT];
    logic         d_busy  [NDUT];
    logic         d_ovr   [NDUT];

    always #5 clock = ~clock;

    // Instance 0: unipolar single-shot, 1: bipolar single-shot, 2: unipolar continuous.
    sc_stream_decoder #(.N(N), .BIPOLAR(0), .CONTINUOUS(0)) u_uni (
        .clock(clock), .reset(reset), .start(start), .sc_bit(sc_bit), .sc_valid(sc_valid),
        .out_ready(out_ready), .out_value(d_value[0]), .out_valid(d_valid[0]),
        .busy(d_busy[0]), .overrun(d_ovr[0]));

    sc_stream_decoder #(.N(N), .BIPOLAR(1), .CONTINUOUS(0)) u_bip (
        .clock(clock), .reset(reset), .start(start), .sc_bit(sc_bit), .sc_valid(sc_valid),
        .out_ready(out_ready), .out_value(d_value[1]), .out_valid(d_valid[1]),
        .busy(d_busy[1]), .overrun(d_ovr[1]));

    sc_stream_decoder #(.N(N), .BIPOLAR(0), .CONTINUOUS(1)) u_cont (
        .clock(clock), .reset(reset), .start(start), .sc_bit(sc_bit), .sc_valid(sc_valid),
        .out_ready(out_ready), .out_value(d_value[2]), .out_valid(d_valid[2]),
        .busy(d_busy[2]), .overrun(d_ovr[2]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state: per-window sample and ones tallies plus the output slot.
    bit           m_busy  [NDUT];
    int           m_samp  [NDUT];
    int           m_ones  [NDUT];
    logic [W-1:0] m_value [NDUT];
    bit           m_valid [NDUT];
    bit           m_ovr   [NDUT];

    typedef struct {
        int           n_ones;
        bit           alt;
        bit           stalls;
        logic [W-1:0] exp_u;
        logic [W-1:0] exp_b;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int k, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h want=%h cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            bit load;
            int c;
            load = 1'b0;
            c = 0;
            if (reset) begin
                m_busy[k] = 1'b0; m_samp[k] = 0; m_ones[k] = 0;
                m_value[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
            end else begin
                if (!m_busy[k]) begin
                    if (start) begin
                        m_busy[k] = 1'b1; m_samp[k] = 0; m_ones[k] = 0;
                    end
                end else if (sc_valid) begin
                    m_samp[k] = m_samp[k] + 1;
                    m_ones[k] = m_ones[k] + (sc_bit ? 1 : 0);
                    if (m_samp[k] == WIN) begin
                        load = 1'b1;
                        c = m_ones[k];
                        m_samp[k] = 0;
                        m_ones[k] = 0;
                        m_busy[k] = (k == 2);
                    end
                end
                if (load) begin
                    if (m_valid[k] && !out_ready) m_ovr[k] = 1'b1;
                    m_value[k] = (k == 1) ? W'(2 * c - WIN) : W'(c);
                    m_valid[k] = 1'b1;
                end else if (m_valid[k] && out_ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    endtask

    // One clock: model sees the same inputs as the DUTs, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            check("value",   k, d_value[k],    m_value[k]);
            check("valid",   k, W'(d_valid[k]), W'(m_valid[k]));
            check("busy",    k, W'(d_busy[k]),  W'(m_busy[k]));
            check("overrun", k, W'(d_ovr[k]),   W'(m_ovr[k]));
        end
    endtask

    task automatic feed(input logic b, input logic v);
        sc_bit = b;
        sc_valid = v;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; sc_valid = 1'b0;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_value", k, d_value[k], W'(0));
            check("rst_valid", k, W'(d_valid[k]), W'(0));
            check("rst_busy",  k, W'(d_busy[k]), W'(0));
            check("rst_ovr",   k, W'(d_ovr[k]), W'(0));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sc_valid = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_window(input int n_ones, input bit alt, input bit stalls);
        for (int i = 0; i < WIN; i++) begin
            if (stalls) begin
                for (int s = 0; s < 3; s++) begin
                    if ($urandom_range(2) == 0) feed(1'($urandom_range(1)), 1'b0);
                end
            end
            feed(alt ? ((i % 2) == 0) : (i < n_ones), 1'b1);
        end
        sc_valid = 1'b0;
    endtask

    int           nv;
    int           t_seen [3];
    logic [W-1:0] v_seen [3];
    int           b2b_ones [3];

    initial begin
        tbl[0] = '{256, 1'b0, 1'b0, W'(256), W'(256)};
        tbl[1] = '{0,   1'b0, 1'b1, W'(0),   10'h300};
        tbl[2] = '{0,   1'b1, 1'b0, W'(128), W'(0)};
        tbl[3] = '{128, 1'b0, 1'b1, W'(128), W'(0)};
        tbl[4] = '{32,  1'b0, 1'b1, W'(32),  10'h340};
        tbl[5] = '{200, 1'b0, 1'b0, W'(200), W'(144)};
        b2b_ones[0] = 10; b2b_ones[1] = 20; b2b_ones[2] = 30;

        do_reset();

        // Directed windows: result one cycle after the last valid sample, busy already low.
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            pulse_start();
            run_window(tbl[t].n_ones, tbl[t].alt, tbl[t].stalls);
            check("tbl_u_value", 0, d_value[0], tbl[t].exp_u);
            check("tbl_b_value", 1, d_value[1], tbl[t].exp_b);
            check("tbl_u_valid", 0, W'(d_valid[0]), W'(1));
            check("tbl_b_valid", 1, W'(d_valid[1]), W'(1));
            check("tbl_u_busy",  0, W'(d_busy[0]), W'(0));
            cycle();
            check("tbl_u_drop",  0, W'(d_valid[0]), W'(0));
        end

        // Backpressure across two continuous windows.
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        run_window(64, 1'b0, 1'b0);
        check("bp_first_value", 2, d_value[2], W'(64));
        check("bp_first_ovr",   2, W'(d_ovr[2]), W'(0));
        run_window(192, 1'b0, 1'b0);
        check("bp_second_value", 2, d_value[2], W'(192));
        check("bp_second_valid", 2, W'(d_valid[2]), W'(1));
        check("bp_second_ovr",   2, W'(d_ovr[2]), W'(1));
        check("bp_single_hold",  0, d_value[0], W'(64));
        check("bp_single_ovr",   0, W'(d_ovr[0]), W'(0));
        out_ready = 1'b1;
        cycle();
        check("bp_drain_valid", 2, W'(d_valid[2]), W'(0));
        check("bp_drain_ovr",   2, W'(d_ovr[2]), W'(1));

        // Reset part-way through a window discards it.
        do_reset();
        pulse_start();
        for (int i = 0; i < 100; i++) feed(1'b1, 1'b1);
        do_reset();
        pulse_start();
        run_window(32, 1'b0, 1'b0);
        check("rstmid_value", 0, d_value[0], W'(32));
        check("rstmid_valid", 0, W'(d_valid[0]), W'(1));
        check("rstmid_ovr",   0, W'(d_ovr[0]), W'(0));

        // Back-to-back continuous windows with the consumer always ready.
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        nv = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WIN; i++) begin
                feed(i < b2b_ones[w], 1'b1);
                if (d_valid[2]) begin
                    if (nv < 3) begin
                        t_seen[nv] = cyc;
                        v_seen[nv] = d_value[2];
                    end
                    nv++;
                end
            end
        end
        sc_valid = 1'b0;
        cycle();
        if (d_valid[2]) nv++;
        check("b2b_count", 2, W'(nv), W'(3));
        for (int w = 0; w < 3; w++) begin
            if (w < nv) check("b2b_value", 2, v_seen[w], W'(b2b_ones[w]));
        end
        if (nv >= 3) begin
            check("b2b_gap1", 2, W'(t_seen[1] - t_seen[0]), W'(WIN));
            check("b2b_gap2", 2, W'(t_seen[2] - t_seen[1]), W'(WIN));
        end
        check("b2b_ovr", 2, W'(d_ovr[2]), W'(0));

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(1499) == 0);
            start     = ($urandom_range(19) == 0);
            sc_bit    = 1'($urandom_range(1));
            sc_valid  = ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
